// File: rtl/seq_mag_cmp.sv
// Bit-serial MSB-first magnitude comparator with early termination.
// Reports gt/eq/lt for signed or unsigned W-bit operands via a start/done handshake.
module seq_mag_cmp #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic         ready,
  output logic         done,
  output logic         agtb,
  output logic         aeqb,
  output logic         altb,
  output logic [1:0]   dbg_state
);

  // Handshake: a request is accepted on a rising edge where start=1 and ready=1;
  // start is ignored otherwise. done pulses for one cycle when the flags update.
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic          bit_a;
  logic          bit_b;
  logic          bits_differ;
  logic          last_bit;

  // Shifting avoids an index wider than the operand when W is 1.
  assign a_sh        = a_q >> idx;
  assign b_sh        = b_q >> idx;
  assign bit_a       = a_sh[0];
  assign bit_b       = b_sh[0];
  assign bits_differ = bit_a ^ bit_b;
  assign last_bit    = (idx == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = CMP;
      CMP:  if (bits_differ || last_bit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == IDLE);
    done      = (state == DONE);
    dbg_state = state;
  end

  // Flipping both MSBs maps two's complement onto offset binary, so the
  // unsigned serial compare yields the signed ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      idx  <= '0;
      agtb <= 1'b0;
      aeqb <= 1'b0;
      altb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a ^ (signed_mode ? MSB_MASK : '0);
            b_q <= b ^ (signed_mode ? MSB_MASK : '0);
            idx <= IW'(W - 1);
          end
        end
        CMP: begin
          if (bits_differ) begin
            agtb <= bit_a & ~bit_b;
            altb <= ~bit_a & bit_b;
            aeqb <= 1'b0;
          end else if (last_bit) begin
            agtb <= 1'b0;
            altb <= 1'b0;
            aeqb <= 1'b1;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Bench for seq_mag_cmp: four builds (W=8,4,1,32) driven on a shared clock and
// checked against an arithmetic reference for relation and latency.
module tb_seq_mag_cmp;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [3:0]        start_v = '0;
  logic [3:0][31:0]  a_v = '0;
  logic [3:0][31:0]  b_v = '0;
  logic [3:0]        sm_v = '0;
  logic [3:0]        rdy;
  logic [3:0]        dn;
  logic [3:0]        gt;
  logic [3:0]        eq;
  logic [3:0]        lt;
  logic [3:0][1:0]   dbg;

  int wd [4] = '{8, 4, 1, 32};
  logic [2:0] last_flags [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mag_cmp #(.W(8)) u_w8 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .signed_mode(sm_v[0]), .ready(rdy[0]), .done(dn[0]), .agtb(gt[0]), .aeqb(eq[0]),
    .altb(lt[0]), .dbg_state(dbg[0]));
  seq_mag_cmp #(.W(4)) u_w4 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]),
    .signed_mode(sm_v[1]), .ready(rdy[1]), .done(dn[1]), .agtb(gt[1]), .aeqb(eq[1]),
    .altb(lt[1]), .dbg_state(dbg[1]));
  seq_mag_cmp #(.W(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
    .signed_mode(sm_v[2]), .ready(rdy[2]), .done(dn[2]), .agtb(gt[2]), .aeqb(eq[2]),
    .altb(lt[2]), .dbg_state(dbg[2]));
  seq_mag_cmp #(.W(32)) u_w32 (
    .clk(clk), .reset_n(reset_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
    .signed_mode(sm_v[3]), .ready(rdy[3]), .done(dn[3]), .agtb(gt[3]), .aeqb(eq[3]),
    .altb(lt[3]), .dbg_state(dbg[3]));

  // Reference: operands as integers (sign-extended when signed), latency from
  // the highest differing bit of the raw operands.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic sm, output int rel, output int n);
    longint m, va, vb;
    logic [31:0] x;
    bit found;
    m  = (longint'(1) << w) - 1;
    va = longint'(av) & m;
    vb = longint'(bv) & m;
    if (sm && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
    if (sm && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    rel = (va > vb) ? 1 : ((va == vb) ? 0 : -1);
    x = av ^ bv;
    n = w;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n = w - i;
        found = 1'b1;
      end
    end
  endfunction

  // Runs one operation from an IDLE cycle (entered at #1 after an edge) and
  // leaves the bench at #1 in the following IDLE cycle.
  task automatic do_op(input int d, input logic [31:0] av, input logic [31:0] bv, input logic sm);
    int w, rel, n, lat, k;
    logic [2:0] exp_f;
    w = wd[d];
    model(w, av, bv, sm, rel, n);
    exp_f = {rel > 0, rel == 0, rel < 0};
    checks++;
    if (rdy[d] !== 1'b1) begin
      failures++;
      $display("FAIL ready_idle dut%0d: got %b want 1", d, rdy[d]);
    end
    a_v[d] = av; b_v[d] = bv; sm_v[d] = sm; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    a_v[d] = $urandom; b_v[d] = $urandom; sm_v[d] = 1'($urandom);
    checks++;
    if (rdy[d] !== 1'b0) begin
      failures++;
      $display("FAIL ready_busy dut%0d: got %b want 0", d, rdy[d]);
    end
    checks++;
    if ({gt[d], eq[d], lt[d]} !== last_flags[d]) begin
      failures++;
      $display("FAIL flags_hold dut%0d: got %b want %b", d, {gt[d], eq[d], lt[d]}, last_flags[d]);
    end
    lat = 0;
    k = 0;
    while (lat == 0 && k < w + 1) begin
      @(posedge clk); #1;
      k++;
      if (dn[d] === 1'b1) lat = k;
    end
    checks++;
    if (lat != n) begin
      failures++;
      $display("FAIL latency dut%0d a=%h b=%h sm=%b: got %0d want %0d", d, av, bv, sm, lat, n);
    end
    if (lat != 0) begin
      checks++;
      if ({gt[d], eq[d], lt[d]} !== exp_f) begin
        failures++;
        $display("FAIL relation dut%0d a=%h b=%h sm=%b: got gt/eq/lt=%b want %b",
                 d, av, bv, sm, {gt[d], eq[d], lt[d]}, exp_f);
      end
      last_flags[d] = exp_f;
    end
    @(posedge clk); #1;
    checks++;
    if (dn[d] !== 1'b0 || rdy[d] !== 1'b1) begin
      failures++;
      $display("FAIL after_done dut%0d: got done=%b ready=%b want done=0 ready=1", d, dn[d], rdy[d]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({rdy[d], dn[d], gt[d], eq[d], lt[d]} !== 5'b10000) begin
        failures++;
        $display("FAIL %s dut%0d: got rdy/done/gt/eq/lt=%b want 10000",
                 tag, d, {rdy[d], dn[d], gt[d], eq[d], lt[d]});
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 4; d++) last_flags[d] = 3'b000;
    @(posedge clk); #1;
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_directed();
    do_op(0, 32'h80, 32'h7F, 1'b0);
    do_op(0, 32'hA5, 32'hA5, 1'b0);
    do_op(0, 32'h01, 32'h00, 1'b0);
    do_op(0, 32'h80, 32'h7F, 1'b1);
    do_op(0, 32'hFF, 32'hFE, 1'b1);
    do_op(3, 32'h1, 32'h0, 1'b0);
    do_op(3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_op(3, 32'h80000000, 32'h7FFFFFFF, 1'b1);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          do_op(2, 32'(i), 32'(j), 1'(s));
  endtask

  task automatic test_exhaustive_w4();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          do_op(1, 32'(i), 32'(j), 1'(s));
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    for (int t = 0; t < 200; t++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra ^ (32'h1 << $urandom_range(0, 7)) : $urandom;
      do_op(0, ra, rb, 1'($urandom));
    end
    for (int t = 0; t < 100; t++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra ^ (32'h1 << $urandom_range(0, 31)) : $urandom;
      do_op(3, ra, rb, 1'($urandom));
    end
  endtask

  // start held high through CMP and DONE with operands changed after accept.
  task automatic test_back_to_back();
    int dones;
    logic [2:0] got_f;
    dones = 0;
    got_f = 3'b000;
    a_v[0] = 32'h33; b_v[0] = 32'h35; sm_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    a_v[0] = 32'hFF; b_v[0] = 32'h00;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (dn[0] === 1'b1) begin
        dones++;
        got_f = {gt[0], eq[0], lt[0]};
      end
    end
    start_v[0] = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL held_start_done_count: got %0d want 1", dones);
    end
    checks++;
    if (got_f !== 3'b001) begin
      failures++;
      $display("FAIL held_start_captured: got gt/eq/lt=%b want 001", got_f);
    end
    last_flags[0] = 3'b001;
    @(posedge clk); #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL held_start_no_extra_accept: got ready=%b want 1", rdy[0]);
    end
    do_op(0, 32'h10, 32'h20, 1'b0);
  endtask

  task automatic test_mid_reset();
    int dones;
    dones = 0;
    a_v[0] = 32'h12; b_v[0] = 32'h13; sm_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (dn[0] === 1'b1) dones++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (dn[0] === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL mid_reset_no_done: got %0d done pulses want 0", dones);
    end
    for (int d = 0; d < 4; d++) last_flags[d] = 3'b000;
    check_reset_outputs("after_mid_reset");
    do_op(0, 32'h7F, 32'h80, 1'b1);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) last_flags[d] = 3'b000;
    test_reset();
    test_directed();
    test_exhaustive_w4();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
